d_rr_arbiter: RTL
=================

# d_rr_arbiter

Two-requester round-robin arbiter that owns the select line of a 2:1 data multiplexer. It shares a single output channel between source "one" and source "two", issues a registered grant to each, and bounds each burst with a counter. It forwards the granted source's data through a one-cycle registered path with a valid strobe. It sits between two producers and any single-port consumer in the datapath.

## Interface
- `DATA_W`, 8, width of `din_one`, `din_two` and `dout`.
- `MAX_BURST`, 4, maximum consecutive granted cycles while the other side waits; legal range is 1 or more.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din_req_one`  in  1  source one requests the channel.
- `din_req_two`  in  1  source two requests the channel.
- `din_one`  in  DATA_W  source one data; sampled when `grant_one & din_req_one`.
- `din_two`  in  DATA_W  source two data; sampled when `grant_two & din_req_two`.
- `grant_one`  out  1  registered grant to source one.
- `grant_two`  out  1  registered grant to source two.
- `dout_sel`  out  1  mux select: 1 selects source one, 0 selects source two.
- `dout`  out  DATA_W  registered forwarded data.
- `dout_vld`  out  1  `dout` holds a transfer completed in the previous cycle.

## Operation
- **States:** IDLE, OWN_ONE, OWN_TWO. `grant_one` is 1 only in OWN_ONE, and `grant_two` is 1 only in OWN_TWO. The two grants are never 1 together.
- **Last-served flag `last`:** resets to "two", so source one wins the first tie.
- **IDLE:**
  - Both requesting: go to the side opposite `last`.
  - Only one requesting: go to that side.
  - Neither requesting: stay in IDLE.
- **OWN_x:**
  - `cnt` increments each cycle in the state.
  - Transfer: a cycle where `grant_x & din_req_x` are both 1.
- **Leaving OWN_x:**
  - `din_req_x` = 0 and other requesting: go to OWN_other and clear `cnt`.
  - `din_req_x` = 0 and other idle: go to IDLE and clear `cnt`.
  - `cnt == MAX_BURST-1` and other requesting: go to OWN_other (forced hand-over) and clear `cnt`.
  - `cnt == MAX_BURST-1` and other idle: stay in OWN_x and clear `cnt` (new burst; no saturation, no wrap past MAX_BURST-1).
- **`last` update:** set to x on every exit from OWN_x.
- **`dout_sel`:**
  - 1 in OWN_ONE, 0 in OWN_TWO.
  - In IDLE it holds its previous value.
- **Datapath:**
  - On a transfer cycle: `dout <= din_x` and `dout_vld <= 1`.
  - Otherwise: `dout_vld <= 0` and `dout` holds its value.
- **Counter width:** clog2(MAX_BURST), minimum 1 bit. With MAX_BURST = 1, the arbiter alternates every cycle while both sources request.
- **Requester rule:** a requester may drop its request at any time. A cycle with the grant high but the request low is not a transfer.
- **Simultaneous events:** when the owner drops its request in the same cycle the burst limit is reached, the request-drop rule takes precedence (result is identical).

## Timing
- **Reset values:**
  - state IDLE, `cnt` 0, `last` two
  - `grant_one` 0, `grant_two` 0, `dout_sel` 0
  - `dout` 0, `dout_vld` 0
- **Reset mid-burst:** the in-flight transfer is discarded. `dout_vld` is 0 in the cycle after `rst`.
- **Request to grant:** 1 cycle. A request first seen at edge N produces the grant high after edge N+1.
- **Transfer to output:** 1 cycle. `dout` and `dout_vld` update at the edge that ends the transfer cycle.
- **Hand-over:** zero idle cycles between the owners' grants when the other side is already requesting.
- **Sustained throughput:** one transfer per cycle while any granted source keeps requesting.
- **Fairness bound:** a waiting requester is granted within MAX_BURST+1 cycles of asserting its request.

## Structure
- Shared package/header `d_arb_pkg`:
  - state encodings IDLE=2'd0, OWN_ONE=2'd1, OWN_TWO=2'd2 (2'd3 is illegal and decodes to IDLE)
  - source identifiers ONE=1'b1, TWO=1'b0
- Sub-module `d_arb_burst_cnt`:
  - inputs: clear, enable
  - output: terminal flag at MAX_BURST-1
  - parameterised by MAX_BURST
- The top level contains the FSM, the `last` flag, and the registered output mux.

## Test plan
- **Reset then a single requester:** `din_req_one` = 1 with `din_one` = 8'hA5. Expect `grant_one` at cycle 1, `dout` = 8'hA5 with `dout_vld` = 1 at cycle 2, and `dout_sel` = 1.
- **Tie from reset:** both requests rise together. Expect OWN_ONE first; after 4 transfers, `grant_two` rises in the next cycle with no gap; after 4 more, ownership returns to one.
- **Lone requester past the limit:** only `din_req_two` held for 10 cycles. Expect `grant_two` continuously high, 10 consecutive `dout_vld` pulses, and `cnt` returning to 0 every 4 cycles.
- **Early release:** source one drops its request after 2 transfers while source two waits. Expect `grant_two` the next cycle; `last` becomes one, so a following tie goes to two.
- **Reset mid-burst:** assert `rst` during OWN_TWO with a transfer pending. Expect all outputs at reset values after the edge, `dout_vld` = 0, and the next tie granted to one.
- **MAX_BURST = 1 build:** both sources request constantly. Expect the grants to alternate one, two, one, … every cycle, with data matching the granted source each cycle.

Source files
------------

// File: rtl/d_arb_pkg.sv
// Shared types for the two-requester round-robin arbiter: FSM encodings,
// source identifiers and the burst-counter width helper.
package d_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_ONE = 2'd1,
        OWN_TWO = 2'd2
    } arb_state_t;

    localparam logic ONE = 1'b1;
    localparam logic TWO = 1'b0;

    // A one-cycle burst still needs a 1-bit counter.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/d_arb_burst_cnt.sv
// Burst-length counter: counts owned cycles and flags the last cycle
// of a burst at MAX_BURST-1.
module d_arb_burst_cnt
    import d_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int            CW   = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] TERM = CW'(MAX_BURST - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gated so an idle arbiter with MAX_BURST == 1 never looks terminal.
    assign terminal = enable & (cnt == TERM);

endmodule

// File: rtl/d_rr_arbiter.sv
// Two-requester round-robin arbiter with burst limit, owning the select of a
// 2:1 mux and forwarding the granted source's data through one register stage.
module d_rr_arbiter
    import d_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_req_one,
    input  logic              din_req_two,
    input  logic [DATA_W-1:0] din_one,
    input  logic [DATA_W-1:0] din_two,
    output logic              grant_one,
    output logic              grant_two,
    output logic              dout_sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       cnt_en, cnt_clear, burst_end;
    logic       mine_req, other_req;
    arb_state_t other_state;
    logic       xfer;

    d_arb_burst_cnt #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .terminal(burst_end)
    );

    assign grant_one = (state == OWN_ONE);
    assign grant_two = (state == OWN_TWO);
    assign xfer      = (grant_one & din_req_one) | (grant_two & din_req_two);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        state_nxt   = IDLE;
        last_nxt    = last;
        cnt_en      = 1'b0;
        cnt_clear   = 1'b0;
        mine_req    = (state == OWN_ONE) ? din_req_one : din_req_two;
        other_req   = (state == OWN_ONE) ? din_req_two : din_req_one;
        other_state = (state == OWN_ONE) ? OWN_TWO : OWN_ONE;

        case (state)
            OWN_ONE, OWN_TWO: begin
                cnt_en = 1'b1;
                if (!mine_req || (burst_end && other_req)) begin
                    cnt_clear = 1'b1;
                    last_nxt  = (state == OWN_ONE) ? ONE : TWO;
                    state_nxt = other_req ? other_state : IDLE;
                end else begin
                    // Burst limit with nobody waiting restarts the burst.
                    cnt_clear = burst_end;
                    state_nxt = state;
                end
            end
            default: begin
                // IDLE and the unused encoding both arbitrate from idle.
                if (din_req_one && din_req_two) begin
                    state_nxt = (last == TWO) ? OWN_ONE : OWN_TWO;
                end else if (din_req_one) begin
                    state_nxt = OWN_ONE;
                end else if (din_req_two) begin
                    state_nxt = OWN_TWO;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= TWO;
            dout_sel <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (state_nxt == OWN_ONE) begin
                dout_sel <= 1'b1;
            end else if (state_nxt == OWN_TWO) begin
                dout_sel <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (xfer) begin
            dout     <= dout_sel ? din_one : din_two;
            dout_vld <= 1'b1;
        end else begin
            dout_vld <= 1'b0;
        end
    end

endmodule
